// File: rtl/apb4_req_bridge.sv
// rtl/apb4_req_bridge.sv - single-outstanding valid/ready request port to APB4 master bridge
// Optional ACCESS timeout: define APB4_REQ_BRIDGE_TIMEOUT_EN.
module apb4_req_bridge #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                      hclk,
  input  logic                      hresetn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
  input  logic [2:0]                req_prot,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_WIDTH-1:0]     paddr,
  output logic [2:0]                pprot,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [DATA_WIDTH-1:0]     pwdata,
  output logic [DATA_WIDTH/8-1:0]   pstrb,
  input  logic [DATA_WIDTH-1:0]     prdata,
  input  logic                      pready,
  input  logic                      pslerr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state;

  // Bus width and timeout bound are only meaningful for 32-bit data and TIMEOUT_CYC >= 2;
  // other settings elaborate an empty marker block so they stand out in the hierarchy.
  if (DATA_WIDTH != 32 || TIMEOUT_CYC < 2) begin : g_unsupported_params
  end

`ifdef APB4_REQ_BRIDGE_TIMEOUT_EN
  // Counter only ever needs to reach TIMEOUT_CYC-1.
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] acc_cnt;
  logic             timed_out;

  assign timed_out = (acc_cnt == CNT_LAST);
`endif

  // Acceptance depends on state alone, never on req_valid.
  assign req_ready = (state == IDLE);

  // Transfer sequencer: IDLE -> SETUP -> ACCESS (until pready) -> RESP (until rsp_ready).
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      pprot     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB4_REQ_BRIDGE_TIMEOUT_EN
      acc_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            paddr  <= req_addr;
            pwdata <= req_wdata;
            pwrite <= req_write;
            pprot  <= req_prot;
            // Reads carry no strobes on APB4.
            pstrb  <= req_write ? req_wstrb : '0;
            psel   <= 1'b1;
            state  <= SETUP;
`ifdef APB4_REQ_BRIDGE_TIMEOUT_EN
            acc_cnt <= '0;
`endif
          end
        end
        SETUP: begin
          // pready is deliberately not looked at here.
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= pslerr;
            state     <= RESP;
          end
`ifdef APB4_REQ_BRIDGE_TIMEOUT_EN
          else if (timed_out) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            state     <= RESP;
          end else begin
            acc_cnt <= acc_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb4_req_bridge.sv
// tb/tb_apb4_req_bridge.sv - self-checking bench for apb4_req_bridge
module tb_apb4_req_bridge;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int TCYC = 4;

  logic          hclk = 1'b0;
  logic          hresetn;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_wstrb;
  logic [2:0]    req_prot;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] paddr;
  logic [2:0]    pprot;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0;
  logic          pslerr = 1'b0;

  apb4_req_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYC(TCYC)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslerr(pslerr)
  );

  always #5 hclk = ~hclk;

  int n_chk = 0;
  int n_err = 0;

  function void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Slave configuration shared by the slave model and the scoreboard.
  int unsigned wait_n;
  logic [31:0] rd_val;
  logic        err_flag;
  logic        setup_ready;

  longint cyc = 0;
  always @(posedge hclk) cyc <= cyc + 1;

  // APB slave: pready after wait_n wait states; optionally pulses pready during SETUP.
  int unsigned acc_k = 0;
  always @(posedge hclk) begin
    #1;
    if (psel && penable) begin
      pready = (acc_k == wait_n);
      prdata = rd_val;
      pslerr = pready && err_flag;
      acc_k++;
    end else begin
      acc_k  = 0;
      pready = setup_ready && psel;
      prdata = ~rd_val;
      pslerr = 1'b0;
    end
  end

  // Transaction-level model: each accepted request owns a timeline
  // psel on [acc+1, done], penable on [acc+2, done], rsp_valid after done.
  bit          busy = 0;
  longint      acc_c, done;
  logic        e_write, e_err;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [3:0]  e_pstrb;
  logic [2:0]  e_prot;
  logic        exp_psel, exp_pen, exp_rv;
  longint      w_eff;

  always @(negedge hclk) begin
    if (!hresetn) begin
      busy = 0;
      chk("rst_psel", psel, 0);
      chk("rst_penable", penable, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_req_ready", req_ready, 1);
    end else begin
      exp_psel = busy && cyc >= acc_c + 1 && cyc <= done;
      exp_pen  = busy && cyc >= acc_c + 2 && cyc <= done;
      exp_rv   = busy && cyc > done;
      chk("m_psel", psel, exp_psel);
      chk("m_penable", penable, exp_pen);
      chk("m_rsp_valid", rsp_valid, exp_rv);
      chk("m_req_ready", req_ready, !busy);
      if (exp_psel) begin
        chk("m_paddr", paddr, e_addr);
        chk("m_pwrite", pwrite, e_write);
        chk("m_pwdata", pwdata, e_wdata);
        chk("m_pstrb", pstrb, e_pstrb);
        chk("m_pprot", pprot, e_prot);
      end
      if (exp_rv) begin
        chk("m_rsp_rdata", rsp_rdata, e_rdata);
        chk("m_rsp_err", rsp_err, e_err);
      end
      if (exp_rv && rsp_ready) begin
        busy = 0;
      end else if (!busy && req_valid) begin
        busy    = 1;
        acc_c   = cyc;
        e_write = req_write;
        e_addr  = req_addr;
        e_wdata = req_wdata;
        e_prot  = req_prot;
        e_pstrb = req_write ? req_wstrb : 4'h0;
        e_rdata = req_write ? 32'h0 : rd_val;
        e_err   = err_flag;
        w_eff   = wait_n;
`ifdef APB4_REQ_BRIDGE_TIMEOUT_EN
        if (w_eff > TCYC - 1) begin
          w_eff   = TCYC - 1;
          e_err   = 1'b1;
          e_rdata = 32'h0;
        end
`endif
        done = cyc + 2 + w_eff;
      end
    end
  end

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p);
    @(posedge hclk); #1;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
    req_prot  = p;
  endtask

  task automatic wait_accept(output longint n);
    n = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge hclk);
      if (req_ready && req_valid) begin
        n = cyc;
        break;
      end
    end
    if (n < 0) chk("accept_bound", 1, 0);
  endtask

  task automatic drop_valid();
    @(posedge hclk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output longint n);
    n = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge hclk);
      if (rsp_valid) begin
        n = cyc;
        break;
      end
    end
    if (n < 0) chk("rsp_bound", 1, 0);
  endtask

  task automatic count_access(output int acc, output longint n);
    acc = 0;
    n = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge hclk);
      if (psel && penable) acc++;
      if (rsp_valid) begin
        n = cyc;
        break;
      end
    end
    if (n < 0) chk("access_bound", 1, 0);
  endtask

  longint n0, n1, n2;
  int     acc;

  initial begin
    hresetn = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_wstrb = '0; req_prot = '0; rsp_ready = 1'b1;
    wait_n = 0; rd_val = '0; err_flag = 1'b0; setup_ready = 1'b0;

    @(posedge hclk); #1;
    chk("reset_paddr", paddr, 0);
    chk("reset_pstrb", pstrb, 0);
    chk("reset_pwdata", pwdata, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_req_ready", req_ready, 1);
    repeat (2) @(posedge hclk);
    #1 hresetn = 1'b1;

    // Zero-wait read: latency pinned by hand.
    wait_n = 0; rd_val = 32'h1234_5678;
    send(1'b0, 32'h0, 32'h1111_2222, 4'hF, 3'b010);
    wait_accept(n0);
    drop_valid();
    @(negedge hclk);
    chk("t1_psel_n1", psel, 1);
    chk("t1_penable_n1", penable, 0);
    @(negedge hclk);
    chk("t1_penable_n2", penable, 1);
    chk("t1_pstrb_read", pstrb, 0);
    @(negedge hclk);
    chk("t1_latency", cyc - n0, 3);
    chk("t1_rsp_valid_n3", rsp_valid, 1);
    chk("t1_rdata", rsp_rdata, 32'h1234_5678);
    chk("t1_err", rsp_err, 0);
    chk("t1_psel_n3", psel, 0);
    @(negedge hclk);
    chk("t1_req_ready_n4", req_ready, 1);

    // Write with 3 wait states, spurious pready during SETUP.
    wait_n = 3; rd_val = 32'hFFFF_0000; setup_ready = 1'b1;
    send(1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF, 3'b001);
    wait_accept(n0);
    drop_valid();
    count_access(acc, n1);
    chk("t2_access_cycles", acc, 4);
    chk("t2_latency", n1 - n0, 6);
    chk("t2_rdata", rsp_rdata, 0);
    chk("t2_err", rsp_err, 0);
    setup_ready = 1'b0;

    // Read with slave error, response back-pressured for 5 cycles.
    @(posedge hclk); #1;
    rsp_ready = 1'b0; wait_n = 1; rd_val = 32'hA5A5_0001; err_flag = 1'b1;
    send(1'b0, 32'h10, 32'h0, 4'h3, 3'b111);
    wait_accept(n0);
    drop_valid();
    wait_rsp(n1);
    chk("t3_err", rsp_err, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge hclk);
      chk("t3_hold_valid", rsp_valid, 1);
      chk("t3_hold_err", rsp_err, 1);
      chk("t3_hold_rdata", rsp_rdata, 32'hA5A5_0001);
      chk("t3_hold_req_ready", req_ready, 0);
    end
    @(posedge hclk); #1;
    rsp_ready = 1'b1; err_flag = 1'b0;
    @(negedge hclk);
    @(negedge hclk);
    chk("t3_req_ready_after", req_ready, 1);

    // Two queued requests with req_valid held high.
    wait_n = 0; rd_val = 32'h0BAD_F00D;
    send(1'b1, 32'h14, 32'h0102_0304, 4'h5, 3'b000);
    wait_accept(n0);
    @(posedge hclk); #1;
    req_write = 1'b0; req_addr = 32'h18; req_wdata = 32'h0506_0708; req_wstrb = 4'hA;
    wait_accept(n1);
    chk("t4_spacing", n1 - n0, 4);
    chk("t4_psel_gap", psel, 0);
    drop_valid();
    wait_rsp(n2);
    chk("t4_rdata", rsp_rdata, 32'h0BAD_F00D);
    chk("t4_latency", n2 - n1, 3);

`ifdef APB4_REQ_BRIDGE_TIMEOUT_EN
    // Slave never ready: forced termination after TCYC ACCESS cycles.
    wait_n = 32'hFFFF_FFFF; rd_val = 32'h7777_7777;
    send(1'b0, 32'h1C, 32'h0, 4'h0, 3'b000);
    wait_accept(n0);
    drop_valid();
    count_access(acc, n1);
    chk("t5_to_access_cycles", acc, 4);
    chk("t5_to_err", rsp_err, 1);
    chk("t5_to_rdata", rsp_rdata, 0);
    @(negedge hclk);
    // pready on the terminal cycle wins.
    wait_n = TCYC - 1;
    send(1'b0, 32'h1C, 32'h0, 4'h0, 3'b000);
    wait_accept(n0);
    drop_valid();
    count_access(acc, n1);
    chk("t5_edge_access_cycles", acc, 4);
    chk("t5_edge_err", rsp_err, 0);
    chk("t5_edge_rdata", rsp_rdata, 32'h7777_7777);
    @(negedge hclk);
    wait_n = 32'hFFFF_FFFF;
    send(1'b0, 32'h24, 32'h0, 4'h0, 3'b000);
    wait_accept(n0);
    drop_valid();
    @(negedge hclk);
    @(negedge hclk);
    chk("t6_in_access", psel && penable, 1);
`else
    // Slave never ready: bridge waits indefinitely.
    wait_n = 32'hFFFF_FFFF; rd_val = 32'h7777_7777;
    send(1'b0, 32'h1C, 32'h0, 4'h0, 3'b000);
    wait_accept(n0);
    drop_valid();
    repeat (1000) @(negedge hclk);
    chk("t5_still_psel", psel, 1);
    chk("t5_still_penable", penable, 1);
    chk("t5_no_rsp", rsp_valid, 0);
`endif

    // Asynchronous reset in ACCESS, then a clean read.
    #2 hresetn = 1'b0;
    #1;
    chk("t6_async_psel", psel, 0);
    chk("t6_async_penable", penable, 0);
    chk("t6_async_rsp_valid", rsp_valid, 0);
    repeat (2) @(posedge hclk);
    #1 hresetn = 1'b1;
    wait_n = 0; rd_val = 32'hCAFE_F00D;
    @(negedge hclk);
    chk("t6_req_ready", req_ready, 1);
    send(1'b0, 32'h20, 32'h0, 4'h0, 3'b100);
    wait_accept(n0);
    drop_valid();
    wait_rsp(n1);
    chk("t6_latency", n1 - n0, 3);
    chk("t6_rdata", rsp_rdata, 32'hCAFE_F00D);
    chk("t6_err", rsp_err, 0);

    repeat (3) @(negedge hclk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    chk("watchdog", 1, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
